// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port and serial/status outputs of uart_tx_fifo
// Ports: data_in/write/clear_overflow come from the host; serial_line, busy, frame_done,
// full, empty, level and overflow come back from the transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_LEN = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_LEN-1:0] data_in;
  logic write;
  logic clear_overflow;
  logic serial_line;
  logic busy;
  logic frame_done;
  logic full;
  logic empty;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic overflow;
  modport master (
    output data_in, write, clear_overflow,
    input serial_line, busy, frame_done, full, empty, level, overflow
  );
  modport slave (
    input data_in, write, clear_overflow,
    output serial_line, busy, frame_done, full, empty, level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered LSB-first asynchronous serial transmitter with parity and stop-bit framing
// Ports: clk; rst_n (synchronous, active low); bus (slave modport): data_in/write push words,
// clear_overflow clears the sticky overflow flag; serial_line (idle high), busy, frame_done
// (one-cycle pulse per frame), full, empty, level (occupancy) and overflow report status.
module uart_tx_fifo #(
  parameter int DATA_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_LEN);
  localparam logic [AW:0] FULL_LEVEL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [DATA_LEN-1:0] shreg;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt;
  logic par, line, busy, done, overflow;
  logic tc, last_stop, push, pop;
  assign tc = div == DW'(CLKS_PER_BIT - 1);
  assign last_stop = state == STOP && tc && bit_cnt == BW'(STOP_BITS - 1);
  // The FSM is the only consumer: it pops when idle or at the edge that ends a frame,
  // which is what makes back-to-back frames gapless.
  assign pop = !bus.empty && (state == IDLE || last_stop);
  assign push = bus.write && !bus.full;
  assign bus.full = level == FULL_LEVEL;
  assign bus.empty = level == '0;
  assign bus.level = level;
  assign bus.overflow = overflow;
  assign bus.serial_line = line;
  assign bus.busy = busy;
  assign bus.frame_done = done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= (bus.write && bus.full) || (overflow && !bus.clear_overflow);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      line <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last_stop;
      div <= (state == IDLE || tc) ? '0 : div + 1'b1;
      if (pop) begin
        shreg <= mem[rd_ptr];
        par <= (^mem[rd_ptr]) ^ (PARITY_MODE == 2);
        bit_cnt <= '0;
        state <= START;
        line <= 1'b0;
        busy <= 1'b1;
      end else if (tc) begin
        case (state)
          START: begin
            state <= DATA;
            line <= shreg[0];
          end
          DATA: begin
            if (bit_cnt == BW'(DATA_LEN - 1)) begin
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
              line <= (PARITY_MODE != 0) ? par : 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg <= shreg >> 1;
              line <= shreg[1];
            end
          end
          PARITY: begin
            state <= STOP;
            line <= 1'b1;
          end
          STOP: begin
            if (last_stop) begin
              state <= IDLE;
              line <= 1'b1;
              busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks of uart_tx_fifo against a frame-level waveform model
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.DATA_LEN(8), .FIFO_DEPTH(4)) a_if ();
  uart_tx_fifo_if #(.DATA_LEN(8), .FIFO_DEPTH(4)) b_if ();
  uart_tx_fifo_if #(.DATA_LEN(5), .FIFO_DEPTH(4)) c_if ();
  uart_tx_fifo #(.DATA_LEN(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  uart_tx_fifo #(.DATA_LEN(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  uart_tx_fifo #(.DATA_LEN(5), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  int compared, mismatched;
  logic la[$], ba[$], fa[$], lb[$], bb[$], fb[$], lc[$], bc[$], fc[$];
  bit e[$], eb[$], ef[$];
  bit pend;
  task automatic tick();
    @(negedge clk);
    la.push_back(a_if.serial_line); ba.push_back(a_if.busy); fa.push_back(a_if.frame_done);
    lb.push_back(b_if.serial_line); bb.push_back(b_if.busy); fb.push_back(b_if.frame_done);
    lc.push_back(c_if.serial_line); bc.push_back(c_if.busy); fc.push_back(c_if.frame_done);
  endtask
  task automatic clear_rec();
    la.delete(); ba.delete(); fa.delete(); lb.delete(); bb.delete(); fb.delete();
    lc.delete(); bc.delete(); fc.delete(); e.delete(); eb.delete(); ef.delete();
    pend = 1'b0;
  endtask
  task automatic model_idle(input int n);
    repeat (n) begin
      e.push_back(1'b1); eb.push_back(1'b0); ef.push_back(pend); pend = 1'b0;
    end
  endtask
  // Expected line per cycle for one frame: start, data LSB first, parity, stop bits.
  task automatic model_frame(input int w, input int dl, input int pm, input int sb);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < dl; i++) bits.push_back(bit'((w >> i) & 1));
    if (pm != 0) bits.push_back(bit'(($countones(w & ((1 << dl) - 1)) % 2) ^ (pm == 2 ? 1 : 0)));
    repeat (sb) bits.push_back(1'b1);
    foreach (bits[k]) repeat (CPB) begin
      e.push_back(bits[k]); eb.push_back(1'b1); ef.push_back(pend); pend = 1'b0;
    end
    pend = 1'b1;
  endtask
  task automatic test_reset();
    a_if.write = 0; a_if.clear_overflow = 0; a_if.data_in = '0;
    b_if.write = 0; b_if.clear_overflow = 0; b_if.data_in = '0;
    c_if.write = 0; c_if.clear_overflow = 0; c_if.data_in = '0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    compared += 9;
    if (a_if.serial_line !== 1'b1) begin mismatched++; $display("FAIL reset_line: got %b want 1", a_if.serial_line); end
    if (a_if.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", a_if.busy); end
    if (a_if.frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", a_if.frame_done); end
    if (a_if.full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", a_if.full); end
    if (a_if.empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", a_if.empty); end
    if (a_if.level !== 3'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", a_if.level); end
    if (a_if.overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", a_if.overflow); end
    if (b_if.serial_line !== 1'b1) begin mismatched++; $display("FAIL reset_line_b: got %b want 1", b_if.serial_line); end
    if (c_if.empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty_c: got %b want 1", c_if.empty); end
  endtask
  task automatic test_single_frame();
    int bl, bs, bf, pos;
    clear_rec();
    a_if.data_in = 8'h0A; a_if.write = 1;
    model_idle(1); model_frame(8'h0A, 8, 1, 1); model_idle(4);
    for (int i = 0; i < e.size(); i++) begin
      tick();
      if (i == 0) begin
        a_if.write = 0; a_if.data_in = 8'($urandom);
        compared += 2;
        if (a_if.level !== 3'd1) begin mismatched++; $display("FAIL single_level1: got %0d want 1", a_if.level); end
        if (a_if.serial_line !== 1'b1) begin mismatched++; $display("FAIL single_line_early: got %b want 1", a_if.serial_line); end
      end
    end
    bl = 0; bs = 0; bf = 0; pos = -1;
    for (int i = 0; i < e.size(); i++) begin
      if (la[i] !== e[i]) bl++;
      if (ba[i] !== eb[i]) bs++;
      if (fa[i] !== ef[i]) bf++;
      if (fa[i] === 1'b1 && pos < 0) pos = i;
    end
    compared += 5;
    if (bl != 0) begin mismatched++; $display("FAIL single_wave: got %0d wrong line samples want 0", bl); end
    if (bs != 0) begin mismatched++; $display("FAIL single_busy: got %0d wrong busy samples want 0", bs); end
    if (bf != 0) begin mismatched++; $display("FAIL single_done: got %0d wrong frame_done samples want 0", bf); end
    if (pos != 45) begin mismatched++; $display("FAIL single_length: frame_done at %0d want 45", pos); end
    if (a_if.empty !== 1'b1) begin mismatched++; $display("FAIL single_empty: got %b want 1", a_if.empty); end
  endtask
  task automatic test_odd_two_stop();
    int bl, bs, pos;
    clear_rec();
    b_if.data_in = 8'h0A; b_if.write = 1;
    model_idle(1); model_frame(8'h0A, 8, 2, 2); model_idle(4);
    for (int i = 0; i < e.size(); i++) begin
      tick();
      if (i == 0) begin b_if.write = 0; b_if.data_in = 8'($urandom); end
    end
    bl = 0; bs = 0; pos = -1;
    for (int i = 0; i < e.size(); i++) begin
      if (lb[i] !== e[i]) bl++;
      if (bb[i] !== eb[i]) bs++;
      if (fb[i] === 1'b1 && pos < 0) pos = i;
    end
    compared += 4;
    if (bl != 0) begin mismatched++; $display("FAIL odd_wave: got %0d wrong line samples want 0", bl); end
    if (bs != 0) begin mismatched++; $display("FAIL odd_busy: got %0d wrong busy samples want 0", bs); end
    if (lb[37] !== 1'b1) begin mismatched++; $display("FAIL odd_parity: got %b want 1", lb[37]); end
    if (pos != 49) begin mismatched++; $display("FAIL odd_length: frame_done at %0d want 49", pos); end
  endtask
  task automatic test_width();
    int bl, pos;
    clear_rec();
    c_if.data_in = 5'h1F; c_if.write = 1;
    model_idle(1); model_frame(5'h1F, 5, 0, 1); model_idle(4);
    for (int i = 0; i < e.size(); i++) begin
      tick();
      if (i == 0) begin c_if.write = 0; c_if.data_in = 5'($urandom); end
    end
    bl = 0; pos = -1;
    for (int i = 0; i < e.size(); i++) begin
      if (lc[i] !== e[i] || bc[i] !== eb[i]) bl++;
      if (fc[i] === 1'b1 && pos < 0) pos = i;
    end
    compared += 2;
    if (bl != 0) begin mismatched++; $display("FAIL width_wave: got %0d wrong samples want 0", bl); end
    if (pos != 29) begin mismatched++; $display("FAIL width_length: frame_done at %0d want 29", pos); end
  endtask
  task automatic test_back_to_back();
    int bl, bs, bf, nd;
    clear_rec();
    a_if.data_in = 8'h10; a_if.write = 1;
    model_idle(1); model_frame(8'h10, 8, 1, 1); model_frame(8'h20, 8, 1, 1); model_frame(8'h30, 8, 1, 1); model_idle(4);
    for (int i = 0; i < e.size(); i++) begin
      tick();
      if (i == 0) a_if.data_in = 8'h20;
      else if (i == 1) a_if.data_in = 8'h30;
      else begin a_if.write = 0; a_if.data_in = 8'($urandom); end
      if (i == 2) begin
        compared++;
        if (a_if.level !== 3'd2) begin mismatched++; $display("FAIL b2b_level: got %0d want 2", a_if.level); end
      end
    end
    bl = 0; bs = 0; bf = 0; nd = 0;
    for (int i = 0; i < e.size(); i++) begin
      if (la[i] !== e[i]) bl++;
      if (ba[i] !== eb[i]) bs++;
      if (fa[i] !== ef[i]) bf++;
      if (fa[i] === 1'b1) nd++;
    end
    compared += 5;
    if (bl != 0) begin mismatched++; $display("FAIL b2b_wave: got %0d wrong line samples want 0", bl); end
    if (bs != 0) begin mismatched++; $display("FAIL b2b_busy: got %0d wrong busy samples want 0", bs); end
    if (bf != 0) begin mismatched++; $display("FAIL b2b_done: got %0d wrong frame_done samples want 0", bf); end
    if (nd != 3) begin mismatched++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
    if (a_if.level !== 3'd0) begin mismatched++; $display("FAIL b2b_level_end: got %0d want 0", a_if.level); end
  endtask
  task automatic test_overflow();
    int w[6];
    int bl, nd;
    foreach (w[k]) w[k] = $urandom_range(0, 255);
    clear_rec();
    a_if.data_in = 8'(w[0]); a_if.write = 1;
    model_idle(1);
    for (int k = 0; k < 5; k++) model_frame(w[k], 8, 1, 1);
    model_idle(4);
    for (int i = 0; i < e.size(); i++) begin
      tick();
      if (i < 5) begin
        a_if.data_in = 8'(w[i + 1]);
      end else if (i == 5) begin
        compared += 4;
        if (a_if.level !== 3'd4) begin mismatched++; $display("FAIL ovf_level: got %0d want 4", a_if.level); end
        if (a_if.full !== 1'b1) begin mismatched++; $display("FAIL ovf_full: got %b want 1", a_if.full); end
        if (a_if.empty !== 1'b0) begin mismatched++; $display("FAIL ovf_empty: got %b want 0", a_if.empty); end
        if (a_if.overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b want 1", a_if.overflow); end
        a_if.data_in = 8'($urandom); a_if.clear_overflow = 1;
      end else if (i == 6) begin
        compared += 2;
        if (a_if.overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set_wins: got %b want 1", a_if.overflow); end
        if (a_if.level !== 3'd4) begin mismatched++; $display("FAIL ovf_level_hold: got %0d want 4", a_if.level); end
        a_if.write = 0;
      end else if (i == 7) begin
        compared++;
        if (a_if.overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b want 0", a_if.overflow); end
        a_if.clear_overflow = 0;
      end
    end
    bl = 0; nd = 0;
    for (int i = 0; i < e.size(); i++) begin
      if (la[i] !== e[i] || fa[i] !== ef[i]) bl++;
      if (fa[i] === 1'b1) nd++;
    end
    compared += 3;
    if (bl != 0) begin mismatched++; $display("FAIL ovf_wave: got %0d wrong samples want 0", bl); end
    if (nd != 5) begin mismatched++; $display("FAIL ovf_frames: got %0d want 5", nd); end
    if (a_if.level !== 3'd0) begin mismatched++; $display("FAIL ovf_level_end: got %0d want 0", a_if.level); end
  endtask
  task automatic test_reset_mid_frame();
    int bad;
    clear_rec();
    a_if.data_in = 8'hA5; a_if.write = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) a_if.data_in = 8'h3C;
      else begin a_if.write = 0; a_if.data_in = 8'($urandom); end
    end
    compared += 3;
    if (la[9] !== 1'b0) begin mismatched++; $display("FAIL mid_line_before: got %b want 0", la[9]); end
    if (ba[9] !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b want 1", ba[9]); end
    if (a_if.level !== 3'd1) begin mismatched++; $display("FAIL mid_level_before: got %0d want 1", a_if.level); end
    rst_n = 0;
    tick();
    rst_n = 1;
    compared += 5;
    if (a_if.serial_line !== 1'b1) begin mismatched++; $display("FAIL mid_line: got %b want 1", a_if.serial_line); end
    if (a_if.busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy: got %b want 0", a_if.busy); end
    if (a_if.level !== 3'd0) begin mismatched++; $display("FAIL mid_level: got %0d want 0", a_if.level); end
    if (a_if.empty !== 1'b1) begin mismatched++; $display("FAIL mid_empty: got %b want 1", a_if.empty); end
    if (a_if.frame_done !== 1'b0) begin mismatched++; $display("FAIL mid_done: got %b want 0", a_if.frame_done); end
    bad = 0;
    repeat (60) begin
      tick();
      if (a_if.serial_line !== 1'b1 || a_if.frame_done !== 1'b0 || a_if.busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL mid_quiet: got %0d active samples want 0", bad); end
  endtask
  task automatic test_random();
    int w[4];
    int n, j, gap, bl, nd;
    repeat (4) begin
      n = $urandom_range(1, 4);
      foreach (w[k]) w[k] = $urandom_range(0, 255);
      clear_rec();
      a_if.data_in = 8'(w[0]); a_if.write = 1;
      model_idle(1);
      for (int k = 0; k < n; k++) model_frame(w[k], 8, 1, 1);
      model_idle(3);
      j = 1;
      gap = $urandom_range(0, 3);
      for (int i = 0; i < e.size(); i++) begin
        tick();
        if (j < n && gap == 0) begin
          a_if.data_in = 8'(w[j]); a_if.write = 1;
          j++;
          gap = $urandom_range(0, 3);
        end else begin
          a_if.write = 0; a_if.data_in = 8'($urandom);
          if (gap > 0) gap--;
        end
      end
      bl = 0; nd = 0;
      for (int i = 0; i < e.size(); i++) begin
        if (la[i] !== e[i] || ba[i] !== eb[i] || fa[i] !== ef[i]) bl++;
        if (fa[i] === 1'b1) nd++;
      end
      compared += 3;
      if (bl != 0) begin mismatched++; $display("FAIL random_wave: got %0d wrong samples want 0 (n=%0d)", bl, n); end
      if (nd != n) begin mismatched++; $display("FAIL random_frames: got %0d want %0d", nd, n); end
      if (a_if.level !== 3'd0) begin mismatched++; $display("FAIL random_level_end: got %0d want 0", a_if.level); end
    end
  endtask
  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_single_frame();
    test_odd_two_stop();
    test_width();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
